// File: rtl/seq_38_decoder_pkg.sv
// Shared widths, FSM state type and the code-to-one-hot helper for the 3-to-8 decoder.
package seq_38_decoder_pkg;

   localparam int unsigned CODE_W     = 3;
   localparam int unsigned OUT_W      = 8;
   localparam int unsigned FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      GAP
   } state_t;

   function automatic logic [OUT_W-1:0] onehot8(input logic [CODE_W-1:0] code);
      logic [OUT_W-1:0] word;
      word       = '0;
      word[code] = 1'b1;
      return word;
   endfunction

endpackage

// File: rtl/seq_38_decoder_code_fifo.sv
// Two-entry synchronous FIFO holding pending codes; a push is refused whenever full.
module code_fifo
   import seq_38_decoder_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [CODE_W-1:0] wdata,
   output logic [CODE_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic              empty_next
);

   logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
   logic [CODE_W-1:0] mem_d [FIFO_DEPTH];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;
   logic              do_push, do_pop;

   assign full  = (count_q == 2'(FIFO_DEPTH));
   assign empty = (count_q == 2'd0);
   assign rdata = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d    = count_q + 2'(do_push) - 2'(do_pop);
      empty_next = (count_d == 2'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/seq_38_decoder.sv
// Sequential 3-to-8 decoder: buffers codes in a small FIFO and replays each as a timed one-hot strobe.
module seq_38_decoder #(
   parameter int unsigned HOLD = 4,
   parameter int unsigned GAP  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] Din,
   input  logic       Din_valid,
   output logic       Din_ready,
   input  logic       en,
   output logic [7:0] Dout,
   output logic       Dout_valid,
   output logic       busy
);
   import seq_38_decoder_pkg::*;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] dout_q, dout_d;
   logic       dout_valid_q, dout_valid_d;
   logic       busy_q, busy_d;

   logic [2:0] head;
   logic       fifo_full, fifo_empty, fifo_empty_next;
   logic       pop, start, word_done;

   code_fifo u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (Din_valid),
      .pop        (pop),
      .wdata      (Din),
      .rdata      (head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .empty_next (fifo_empty_next)
   );

   assign Din_ready  = !fifo_full;
   assign Dout       = dout_q;
   assign Dout_valid = dout_valid_q;
   assign busy       = busy_q;

   // The parameter GAP shadows the imported state name, so the state is package-qualified.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dout_d    = dout_q;
      pop       = 1'b0;
      word_done = 1'b0;
      start     = en && !fifo_empty;
      case (state_q)
         IDLE: word_done = 1'b1;
         DRIVE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (GAP != 0) begin
               dout_d  = '0;
               cnt_d   = 8'(GAP - 1);
               state_d = seq_38_decoder_pkg::GAP;
            end else begin
               word_done = 1'b1;
            end
         end
         seq_38_decoder_pkg::GAP: begin
            if (cnt_q != '0) cnt_d = cnt_q - 8'd1;
            else             word_done = 1'b1;
         end
         default: word_done = 1'b1;
      endcase
      if (word_done) begin
         if (start) begin
            pop     = 1'b1;
            dout_d  = onehot8(head);
            cnt_d   = 8'(HOLD - 1);
            state_d = DRIVE;
         end else begin
            dout_d  = '0;
            state_d = IDLE;
         end
      end
      dout_valid_d = |dout_d;
      busy_d       = (state_d != IDLE) || !fifo_empty_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         busy_q       <= busy_d;
      end
   end

endmodule

// File: tb/tb_seq_38_decoder.sv
// Self-checking bench for seq_38_decoder: scoreboard of expected one-hot words plus per-scenario tasks.
module tb_seq_38_decoder;

   localparam int unsigned HOLD_T = 4;
   localparam int unsigned GAP_T  = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [2:0] Din = '0;
   logic       Din_valid = 1'b0;
   logic       Din_ready;
   logic [7:0] Dout;
   logic       Dout_valid;
   logic       busy;

   logic [2:0] Din_2 = '0;
   logic       Din_valid_2 = 1'b0;
   logic       Din_ready_2;
   logic [7:0] Dout_2;
   logic       Dout_valid_2;
   logic       busy_2;

   int         n_checks = 0;
   int         n_fail = 0;

   logic [7:0] exp_q [$];
   logic [7:0] exp_q2 [$];
   bit         mon_off = 1'b1;
   int         run_left = 0;
   int         gap_left = 0;
   logic [7:0] cur_word = '0;
   logic [7:0] mon_w;

   always #5 clk = ~clk;

   seq_38_decoder #(.HOLD(HOLD_T), .GAP(GAP_T)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Din        (Din),
      .Din_valid  (Din_valid),
      .Din_ready  (Din_ready),
      .en         (en),
      .Dout       (Dout),
      .Dout_valid (Dout_valid),
      .busy       (busy)
   );

   seq_38_decoder #(.HOLD(1), .GAP(0)) dut_2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .Din        (Din_2),
      .Din_valid  (Din_valid_2),
      .Din_ready  (Din_ready_2),
      .en         (1'b1),
      .Dout       (Dout_2),
      .Dout_valid (Dout_valid_2),
      .busy       (busy_2)
   );

   function automatic logic [7:0] expect_word(input logic [2:0] c);
      logic [7:0] one;
      one = 8'h01;
      return one << c;
   endfunction

   // Scoreboard: each new nonzero word must match the oldest expected code, last HOLD cycles
   // and be separated from the previous word by at least GAP zero cycles.
   always @(posedge clk) begin
      #1;
      if (!mon_off) begin
         n_checks++;
         if (Dout_valid !== (|Dout)) begin
            n_fail++;
            $display("FAIL valid_flag: Dout_valid=%b Dout=%h", Dout_valid, Dout);
         end
         if (Dout !== 8'h00) begin
            if (run_left == 0) begin
               n_checks++;
               if (gap_left != 0) begin
                  n_fail++;
                  $display("FAIL gap_short: word %h arrived with %0d gap cycles left", Dout, gap_left);
               end else if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_word: got %h, expected none", Dout);
               end else begin
                  mon_w = exp_q.pop_front();
                  if (Dout !== mon_w) begin
                     n_fail++;
                     $display("FAIL word_order: got %h, expected %h", Dout, mon_w);
                  end
               end
               run_left = HOLD_T;
               cur_word = Dout;
            end else begin
               n_checks++;
               if (Dout !== cur_word) begin
                  n_fail++;
                  $display("FAIL word_changed: got %h, expected %h", Dout, cur_word);
               end
            end
            run_left--;
            if (run_left == 0) gap_left = GAP_T;
         end else begin
            if (run_left != 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL hold_short: word %h ended with %0d cycles left", cur_word, run_left);
               run_left = 0;
            end
            if (gap_left != 0) gap_left--;
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push_code(input logic [2:0] c, input int limit);
      int n;
      n = 0;
      Din       = c;
      Din_valid = 1'b1;
      while (!Din_ready && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!Din_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL push_timeout: Din_ready=%b, required 1 within %0d cycles", Din_ready, limit);
      end else begin
         exp_q.push_back(expect_word(c));
      end
      @(negedge clk);
      Din_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < limit) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL idle_timeout: busy=%b pending=%0d, required busy=0 pending=0", busy, exp_q.size());
      end
   endtask

   task automatic test_reset();
      Din       = 3'd5;
      Din_valid = 1'b1;
      en        = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (Dout !== 8'h00 || Dout_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: Dout=%h valid=%b busy=%b, required 00/0/0", Dout, Dout_valid, busy);
      end
      n_checks++;
      if (Din_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: Din_ready=%b, required 1", Din_ready);
      end
      rst_n     = 1'b1;
      Din_valid = 1'b0;
      mon_off   = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || Dout !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_discard: busy=%b Dout=%h, required 0/00", busy, Dout);
      end
   endtask

   task automatic test_single();
      en = 1'b1;
      push_code(3'd5, 10);
      n_checks++;
      if (Dout !== 8'h00) begin
         n_fail++;
         $display("FAIL single_latency: Dout=%h at push edge, required 00", Dout);
      end
      for (int i = 0; i < int'(HOLD_T); i++) begin
         @(negedge clk);
         n_checks++;
         if (Dout !== 8'h20 || Dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_hold[%0d]: Dout=%h valid=%b, required 20/1", i, Dout, Dout_valid);
         end
      end
      @(negedge clk);
      n_checks++;
      if (Dout !== 8'h00 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_gap: Dout=%h busy=%b, required 00/1", Dout, busy);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] codes [3];
      codes = '{3'd0, 3'd7, 3'd2};
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (Din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready[%0d]: Din_ready=%b, required 1", i, Din_ready);
         end
         push_code(codes[i], 1);
      end
      wait_idle(60);
   endtask

   task automatic test_full_fifo();
      en = 1'b0;
      push_code(3'd1, 5);
      push_code(3'd6, 5);
      n_checks++;
      if (Din_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_ready: Din_ready=%b after two pushes, required 0", Din_ready);
      end
      Din       = 3'd3;
      Din_valid = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (Din_ready !== 1'b0 || Dout !== 8'h00) begin
         n_fail++;
         $display("FAIL full_hold: Din_ready=%b Dout=%h, required 0/00", Din_ready, Dout);
      end
      en = 1'b1;
      push_code(3'd3, 20);
      wait_idle(60);
   endtask

   task automatic test_en_drop();
      en = 1'b1;
      push_code(3'd4, 5);
      @(negedge clk);
      n_checks++;
      if (Dout !== 8'h10) begin
         n_fail++;
         $display("FAIL en_drop_start: Dout=%h, required 10", Dout);
      end
      en = 1'b0;
      push_code(3'd1, 5);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (Dout === 8'h02) begin
            n_fail++;
            $display("FAIL en_drop_block[%0d]: Dout=%h while en low, required not 02", i, Dout);
         end
      end
      n_checks++;
      if (Dout !== 8'h00 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL en_drop_wait: Dout=%h busy=%b, required 00/1", Dout, busy);
      end
      en = 1'b1;
      wait_idle(30);
   endtask

   task automatic test_reset_mid();
      en = 1'b1;
      push_code(3'd4, 5);
      push_code(3'd2, 5);
      n_checks++;
      if (Dout !== 8'h10) begin
         n_fail++;
         $display("FAIL rst_mid_pre: Dout=%h, required 10", Dout);
      end
      mon_off = 1'b1;
      rst_n   = 1'b0;
      @(negedge clk);
      n_checks++;
      if (Dout !== 8'h00 || Dout_valid !== 1'b0 || busy !== 1'b0 || Din_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid: Dout=%h valid=%b busy=%b ready=%b, required 00/0/0/1",
                  Dout, Dout_valid, busy, Din_ready);
      end
      rst_n = 1'b1;
      exp_q.delete();
      run_left = 0;
      gap_left = 0;
      mon_off  = 1'b0;
      repeat (6) @(negedge clk);
      n_checks++;
      if (Dout !== 8'h00 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_lost: Dout=%h busy=%b, required 00/0", Dout, busy);
      end
   endtask

   task automatic test_gap0_stream();
      logic [7:0] w;
      for (int k = 0; k < 10; k++) begin
         if (k < 8) begin
            Din_2       = 3'(k);
            Din_valid_2 = 1'b1;
            n_checks++;
            if (Din_ready_2 !== 1'b1) begin
               n_fail++;
               $display("FAIL stream_ready[%0d]: Din_ready=%b, required 1", k, Din_ready_2);
            end else begin
               exp_q2.push_back(expect_word(3'(k)));
            end
         end else begin
            Din_valid_2 = 1'b0;
         end
         @(negedge clk);
         if (k == 0 || exp_q2.size() == 0) w = 8'h00;
         else                              w = exp_q2.pop_front();
         n_checks++;
         if (Dout_2 !== w || Dout_valid_2 !== (|w)) begin
            n_fail++;
            $display("FAIL stream_word[%0d]: Dout=%h valid=%b, required %h/%b", k, Dout_2, Dout_valid_2, w, |w);
         end
      end
      Din_valid_2 = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_full_fifo();
      test_en_drop();
      test_reset_mid();
      test_gap0_stream();
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
